cache_axi_bridge: RTL and testbench

//  Sits directly below the L1 cache. Converts the cache-side rd_*/ret_*/wr_* line-refill and write-back requests into AXI4 AR/R/AW/W/B transactions.

---
 rtl/cache_axi_bridge_if.sv | 59 +++++
 rtl/cache_axi_bridge.sv | 152 +++++++++++++++
 tb/tb_cache_axi_bridge.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_bridge_if.sv
// Signal bundle between the L1 cache, the cache/AXI bridge and the AXI4 slave.
// The master modport is the bridge's view; the slave modport is the environment's.
interface cache_axi_bridge_if #(
  parameter int LINE_BEATS = 4
);
  logic                    rd_req;
  logic [2:0]              rd_type;
  logic [31:0]             rd_addr;
  logic                    rd_rdy;
  logic                    ret_valid;
  logic                    ret_last;
  logic [31:0]             ret_data;

  logic                    wr_req;
  logic [2:0]              wr_type;
  logic [31:0]             wr_addr;
  logic [3:0]              wr_wstrb;
  logic [32*LINE_BEATS-1:0] wr_data;
  logic                    wr_rdy;

  logic [31:0]             araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic                    arvalid;
  logic                    arready;
  logic [31:0]             rdata;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  logic [31:0]             awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic                    awvalid;
  logic                    awready;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic                    bvalid;
  logic                    bready;

  modport master (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
           arready, rdata, rlast, rvalid, awready, wready, bvalid,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
           araddr, arlen, arsize, arvalid, rready,
           awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
           arready, rdata, rlast, rvalid, awready, wready, bvalid,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
           araddr, arlen, arsize, arvalid, rready,
           awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI4 bridge: independent read and write FSMs turn L1 line refills and
// write-backs into AR/R and AW/W/B bursts, with a one-line write buffer.
module cache_axi_bridge #(
  parameter int LINE_BEATS = 4,
  parameter int HAZARD_CHK = 1
) (
  input  logic               clk,
  input  logic               resetn,
  cache_axi_bridge_if.master bus
);
  localparam int         CNT_W    = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int         OFF_W    = $clog2(LINE_BEATS * 4);
  localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wr_state_t;

  function automatic logic [7:0] len_of(input logic [2:0] t);
    return (t == 3'b100) ? LINE_LEN : 8'd0;
  endfunction

  function automatic logic [2:0] size_of(input logic [2:0] t);
    return (t == 3'b100) ? 3'b010 : {1'b0, t[1:0]};
  endfunction

  rd_state_t        rd_state, rd_next;
  wr_state_t        wr_state, wr_next;
  logic [31:0]      ar_addr;
  logic [7:0]       ar_len;
  logic [2:0]       ar_size;
  logic [31:0]      buf_addr;
  logic [7:0]       buf_len;
  logic [2:0]       buf_size;
  logic [3:0]       buf_strb;
  logic [31:0]      buf_beat [LINE_BEATS];
  logic [CNT_W-1:0] w_cnt;
  logic             hazard;
  logic             rd_take;
  logic             wr_take;
  logic             w_fire;

  // A refill must not overtake a write-back of the same line that is still unacknowledged.
  assign hazard  = (HAZARD_CHK != 0) && (wr_state != W_IDLE) &&
                   (bus.rd_addr[31:OFF_W] == buf_addr[31:OFF_W]);
  assign rd_take = (rd_state == R_IDLE) && bus.rd_req && !hazard;
  assign wr_take = (wr_state == W_IDLE) && bus.wr_req;
  assign w_fire  = (wr_state == W_DATA) && bus.wready;

  assign bus.araddr   = ar_addr;
  assign bus.arlen    = ar_len;
  assign bus.arsize   = ar_size;
  assign bus.ret_data = bus.rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state <= R_IDLE;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
    end else begin
      rd_state <= rd_next;
      if (rd_take) begin
        ar_addr <= bus.rd_addr;
        ar_len  <= len_of(bus.rd_type);
        ar_size <= size_of(bus.rd_type);
      end
    end
  end

  always_comb begin
    rd_next       = rd_state;
    bus.rd_rdy    = 1'b0;
    bus.arvalid   = 1'b0;
    bus.rready    = 1'b0;
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        bus.rd_rdy = !hazard;
        if (rd_take) rd_next = R_AR;
      end
      R_AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) rd_next = R_DATA;
      end
      R_DATA: begin
        bus.rready    = 1'b1;
        bus.ret_valid = bus.rvalid;
        bus.ret_last  = bus.rvalid && bus.rlast;
        if (bus.rvalid && bus.rlast) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  assign bus.awaddr = buf_addr;
  assign bus.awlen  = buf_len;
  assign bus.awsize = buf_size;
  assign bus.wdata  = buf_beat[w_cnt];
  assign bus.wstrb  = buf_strb;
  assign bus.wlast  = (wr_state == W_DATA) && ({{(8-CNT_W){1'b0}}, w_cnt} == buf_len);

  // The whole line is captured on accept so the cache can drop wr_req immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state <= W_IDLE;
      buf_addr <= '0;
      buf_len  <= '0;
      buf_size <= '0;
      buf_strb <= '0;
      w_cnt    <= '0;
      for (int k = 0; k < LINE_BEATS; k++) buf_beat[k] <= '0;
    end else begin
      wr_state <= wr_next;
      if (wr_take) begin
        buf_addr <= bus.wr_addr;
        buf_len  <= len_of(bus.wr_type);
        buf_size <= size_of(bus.wr_type);
        buf_strb <= (bus.wr_type == 3'b100) ? 4'hf : bus.wr_wstrb;
        for (int k = 0; k < LINE_BEATS; k++) buf_beat[k] <= bus.wr_data[32*k +: 32];
      end
      if (w_fire) w_cnt <= bus.wlast ? '0 : w_cnt + 1'b1;
    end
  end

  always_comb begin
    wr_next     = wr_state;
    bus.wr_rdy  = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        bus.wr_rdy = 1'b1;
        if (bus.wr_req) wr_next = W_AW;
      end
      W_AW: begin
        bus.awvalid = 1'b1;
        if (bus.awready) wr_next = W_DATA;
      end
      W_DATA: begin
        bus.wvalid = 1'b1;
        if (bus.wready && bus.wlast) wr_next = W_B;
      end
      W_B: begin
        bus.bready = 1'b1;
        if (bus.bvalid) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: a transaction-level model is compared every
// cycle, and literal expectations pin the key scenarios.
module tb_cache_axi_bridge;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cache_axi_bridge_if #(.LINE_BEATS(LB)) bus ();

  cache_axi_bridge #(.LINE_BEATS(LB), .HAZARD_CHK(1)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Model state: which phase each channel's single transaction is in.
  int          m_rd = 0;
  int          m_wr = 0;
  int          m_idx = 0;
  logic [31:0] m_ar_addr;
  logic [2:0]  m_ar_type;
  logic [31:0] m_aw_addr;
  logic [2:0]  m_aw_type;
  logic [3:0]  m_w_strb;
  logic [31:0] m_beats [LB];

  function automatic int beats_of(input logic [2:0] t);
    return (t == 3'b100) ? LB : 1;
  endfunction

  function automatic logic [2:0] size_of(input logic [2:0] t);
    return (t == 3'b100) ? 3'd2 : {1'b0, t[1:0]};
  endfunction

  function automatic logic exp_rd_rdy();
    return (m_rd == 0) && !((m_wr != 0) && (bus.rd_addr[31:4] == m_aw_addr[31:4]));
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_rd  <= 0;
      m_wr  <= 0;
      m_idx <= 0;
    end else begin
      case (m_rd)
        0: if (bus.rd_req && exp_rd_rdy()) begin
          m_rd      <= 1;
          m_ar_addr <= bus.rd_addr;
          m_ar_type <= bus.rd_type;
        end
        1: if (bus.arready) m_rd <= 2;
        2: if (bus.rvalid && bus.rlast) m_rd <= 0;
        default: m_rd <= 0;
      endcase
      case (m_wr)
        0: if (bus.wr_req) begin
          m_wr      <= 1;
          m_idx     <= 0;
          m_aw_addr <= bus.wr_addr;
          m_aw_type <= bus.wr_type;
          m_w_strb  <= (bus.wr_type == 3'b100) ? 4'hf : bus.wr_wstrb;
          for (int k = 0; k < LB; k++) m_beats[k] <= bus.wr_data[32*k +: 32];
        end
        1: if (bus.awready) m_wr <= 2;
        2: if (bus.wready) begin
          if (m_idx == beats_of(m_aw_type) - 1) begin
            m_wr  <= 3;
            m_idx <= 0;
          end else begin
            m_idx <= m_idx + 1;
          end
        end
        3: if (bus.bvalid) m_wr <= 0;
        default: m_wr <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    checkOutput("cmp_rd_rdy", bus.rd_rdy, exp_rd_rdy());
    checkOutput("cmp_wr_rdy", bus.wr_rdy, m_wr == 0);
    checkOutput("cmp_arvalid", bus.arvalid, m_rd == 1);
    checkOutput("cmp_rready", bus.rready, m_rd == 2);
    checkOutput("cmp_ret_valid", bus.ret_valid, (m_rd == 2) && bus.rvalid);
    checkOutput("cmp_ret_last", bus.ret_last, (m_rd == 2) && bus.rvalid && bus.rlast);
    checkOutput("cmp_awvalid", bus.awvalid, m_wr == 1);
    checkOutput("cmp_wvalid", bus.wvalid, m_wr == 2);
    checkOutput("cmp_bready", bus.bready, m_wr == 3);
    if (m_rd == 1) begin
      checkOutput("cmp_araddr", bus.araddr, m_ar_addr);
      checkOutput("cmp_arlen", bus.arlen, 32'(beats_of(m_ar_type) - 1));
      checkOutput("cmp_arsize", bus.arsize, size_of(m_ar_type));
    end
    if ((m_rd == 2) && bus.rvalid) checkOutput("cmp_ret_data", bus.ret_data, bus.rdata);
    if (m_wr == 1) begin
      checkOutput("cmp_awaddr", bus.awaddr, m_aw_addr);
      checkOutput("cmp_awlen", bus.awlen, 32'(beats_of(m_aw_type) - 1));
      checkOutput("cmp_awsize", bus.awsize, size_of(m_aw_type));
    end
    if (m_wr == 2) begin
      checkOutput("cmp_wdata", bus.wdata, m_beats[m_idx]);
      checkOutput("cmp_wstrb", bus.wstrb, m_w_strb);
      checkOutput("cmp_wlast", bus.wlast, m_idx == beats_of(m_aw_type) - 1);
    end
    if (!resetn) begin
      checkOutput("cmp_rst_araddr", bus.araddr, 32'h0);
      checkOutput("cmp_rst_awaddr", bus.awaddr, 32'h0);
    end
  end

  task automatic applyStimulus();
    bus.rd_req   = 1'b0;
    bus.rd_type  = 3'b000;
    bus.rd_addr  = 32'h0;
    bus.wr_req   = 1'b0;
    bus.wr_type  = 3'b000;
    bus.wr_addr  = 32'h0;
    bus.wr_wstrb = 4'h0;
    bus.wr_data  = '0;
    bus.arready  = 1'b0;
    bus.rdata    = 32'h0;
    bus.rlast    = 1'b0;
    bus.rvalid   = 1'b0;
    bus.awready  = 1'b0;
    bus.wready   = 1'b0;
    bus.bvalid   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd_beats [4];
    logic [31:0] wr_exp [6];
    logic        wr_pat [6];
    logic [31:0] acc [$];
    int          ret_cnt;

    rd_beats = '{32'h11, 32'h22, 32'h33, 32'h44};
    applyStimulus();
    repeat (2) @(negedge clk);
    checkOutput("rst_arvalid", bus.arvalid, 1'b0);
    checkOutput("rst_rd_rdy", bus.rd_rdy, 1'b1);
    checkOutput("rst_wr_rdy", bus.wr_rdy, 1'b1);
    checkOutput("rst_arlen", bus.arlen, 8'h0);
    step();
    resetn = 1'b1;
    step();

    $display("[TB] test 1: line read");
    bus.rd_req = 1'b1; bus.rd_type = 3'b100; bus.rd_addr = 32'h1C000040;
    @(negedge clk); checkOutput("t1_rd_rdy", bus.rd_rdy, 1'b1);
    step();
    bus.rd_req = 1'b0;
    ret_cnt = 0;
    @(negedge clk);
    checkOutput("t1_arvalid", bus.arvalid, 1'b1);
    checkOutput("t1_araddr", bus.araddr, 32'h1C000040);
    checkOutput("t1_arlen", bus.arlen, 8'd3);
    checkOutput("t1_arsize", bus.arsize, 3'd2);
    step(); step();
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.rvalid = 1'b1; bus.rdata = rd_beats[i]; bus.rlast = (i == 3);
      @(negedge clk);
      if (bus.ret_valid) ret_cnt++;
      checkOutput("t1_ret_data", bus.ret_data, rd_beats[i]);
      checkOutput("t1_ret_last", bus.ret_last, i == 3);
      step();
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    @(negedge clk);
    if (bus.ret_valid) ret_cnt++;
    checkOutput("t1_ret_count", ret_cnt, 4);
    checkOutput("t1_rd_rdy_back", bus.rd_rdy, 1'b1);
    step();

    $display("[TB] test 2: uncached byte read");
    bus.rd_req = 1'b1; bus.rd_type = 3'b000; bus.rd_addr = 32'hBFAF8003;
    step();
    bus.rd_req = 1'b0; bus.arready = 1'b1;
    @(negedge clk);
    checkOutput("t2_araddr", bus.araddr, 32'hBFAF8003);
    checkOutput("t2_arlen", bus.arlen, 8'd0);
    checkOutput("t2_arsize", bus.arsize, 3'd0);
    step();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rlast = 1'b1; bus.rdata = 32'h000000A5;
    @(negedge clk);
    checkOutput("t2_ret_valid", bus.ret_valid, 1'b1);
    checkOutput("t2_ret_last", bus.ret_last, 1'b1);
    checkOutput("t2_ret_data", bus.ret_data, 32'h000000A5);
    step();
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    @(negedge clk); checkOutput("t2_ret_valid_off", bus.ret_valid, 1'b0);
    step();

    $display("[TB] test 3: line write with wready stalls");
    wr_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    wr_exp = '{32'hAAAA0001, 32'hBBBB0002, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004, 32'hDDDD0004};
    bus.wr_req = 1'b1; bus.wr_type = 3'b100; bus.wr_addr = 32'h00001230; bus.wr_wstrb = 4'h0;
    bus.wr_data = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    @(negedge clk); checkOutput("t3_wr_rdy", bus.wr_rdy, 1'b1);
    step();
    bus.wr_req = 1'b0; bus.awready = 1'b1;
    @(negedge clk);
    checkOutput("t3_wr_rdy_busy", bus.wr_rdy, 1'b0);
    checkOutput("t3_awaddr", bus.awaddr, 32'h00001230);
    checkOutput("t3_awlen", bus.awlen, 8'd3);
    checkOutput("t3_awsize", bus.awsize, 3'd2);
    step();
    bus.awready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.wready = wr_pat[i];
      @(negedge clk);
      checkOutput("t3_wdata", bus.wdata, wr_exp[i]);
      checkOutput("t3_wlast", bus.wlast, wr_exp[i] == 32'hDDDD0004);
      checkOutput("t3_wstrb", bus.wstrb, 4'hf);
      if (wr_pat[i] && bus.wvalid) acc.push_back(bus.wdata);
      step();
    end
    bus.wready = 1'b0;
    checkOutput("t3_beats", acc.size(), 4);
    for (int i = 0; i < acc.size() && i < 4; i++)
      checkOutput("t3_beat_order", acc[i], 32'hAAAA0001 + i * 32'h11110001);
    @(negedge clk);
    checkOutput("t3_bready", bus.bready, 1'b1);
    checkOutput("t3_wr_rdy_b", bus.wr_rdy, 1'b0);
    step();
    bus.bvalid = 1'b1;
    @(negedge clk); checkOutput("t3_wr_rdy_bhs", bus.wr_rdy, 1'b0);
    step();
    bus.bvalid = 1'b0;
    @(negedge clk); checkOutput("t3_wr_rdy_after", bus.wr_rdy, 1'b1);
    step();

    $display("[TB] test 4: word write with partial strobe");
    bus.wr_req = 1'b1; bus.wr_type = 3'b010; bus.wr_addr = 32'h00002008; bus.wr_wstrb = 4'b0110;
    bus.wr_data = {96'h0, 32'hCAFEF00D};
    step();
    bus.wr_req = 1'b0; bus.awready = 1'b1;
    @(negedge clk);
    checkOutput("t4_awlen", bus.awlen, 8'd0);
    checkOutput("t4_awsize", bus.awsize, 3'd2);
    step();
    bus.awready = 1'b0; bus.wready = 1'b1;
    @(negedge clk);
    checkOutput("t4_wvalid", bus.wvalid, 1'b1);
    checkOutput("t4_wdata", bus.wdata, 32'hCAFEF00D);
    checkOutput("t4_wstrb", bus.wstrb, 4'b0110);
    checkOutput("t4_wlast", bus.wlast, 1'b1);
    step();
    bus.wready = 1'b0; bus.bvalid = 1'b1;
    step();
    bus.bvalid = 1'b0;
    step();

    $display("[TB] test 5: read-after-write hazard");
    bus.wr_req = 1'b1; bus.wr_type = 3'b100; bus.wr_addr = 32'h00001000;
    bus.wr_data = {32'h4, 32'h3, 32'h2, 32'h1};
    step();
    bus.wr_req = 1'b0; bus.awready = 1'b1;
    step();
    bus.awready = 1'b0; bus.wready = 1'b1;
    repeat (4) step();
    bus.wready = 1'b0;
    bus.rd_req = 1'b1; bus.rd_type = 3'b010; bus.rd_addr = 32'h0000100C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); checkOutput("t5_hazard_block", bus.rd_rdy, 1'b0);
      step();
    end
    bus.rd_addr = 32'h00002000;
    @(negedge clk); checkOutput("t5_other_line", bus.rd_rdy, 1'b1);
    step();
    bus.rd_req = 1'b0; bus.arready = 1'b1;
    step();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rlast = 1'b1; bus.rdata = 32'h2000BEEF;
    step();
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 32'h0000100C;
    @(negedge clk); checkOutput("t5_still_blocked", bus.rd_rdy, 1'b0);
    step();
    bus.bvalid = 1'b1;
    @(negedge clk); checkOutput("t5_blocked_bhs", bus.rd_rdy, 1'b0);
    step();
    bus.bvalid = 1'b0;
    @(negedge clk); checkOutput("t5_released", bus.rd_rdy, 1'b1);
    step();
    bus.rd_req = 1'b0; bus.arready = 1'b1;
    step();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rlast = 1'b1; bus.rdata = 32'h100C100C;
    step();
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    step();

    $display("[TB] concurrent read and write");
    bus.rd_req = 1'b1; bus.rd_type = 3'b100; bus.rd_addr = 32'h00003000;
    bus.wr_req = 1'b1; bus.wr_type = 3'b010; bus.wr_addr = 32'h00004000; bus.wr_wstrb = 4'hf;
    bus.wr_data = {96'h0, 32'h44440000};
    @(negedge clk);
    checkOutput("tc_rd_rdy", bus.rd_rdy, 1'b1);
    checkOutput("tc_wr_rdy", bus.wr_rdy, 1'b1);
    step();
    bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.arready = 1'b1; bus.awready = 1'b1;
    @(negedge clk);
    checkOutput("tc_arvalid", bus.arvalid, 1'b1);
    checkOutput("tc_awvalid", bus.awvalid, 1'b1);
    step();
    bus.arready = 1'b0; bus.awready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.rvalid = 1'b1; bus.rdata = 32'h30000000 + i; bus.rlast = (i == 3);
      bus.wready = (i == 0); bus.bvalid = (i == 1);
      step();
    end
    applyStimulus();
    step();

    $display("[TB] test 6: reset during read burst");
    bus.rd_req = 1'b1; bus.rd_type = 3'b100; bus.rd_addr = 32'h00005000;
    bus.wr_req = 1'b1; bus.wr_type = 3'b100; bus.wr_addr = 32'h00006000;
    step();
    bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.arready = 1'b1;
    step();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h1; bus.rlast = 1'b0;
    @(negedge clk);
    checkOutput("t6_awvalid_pre", bus.awvalid, 1'b1);
    checkOutput("t6_rready_pre", bus.rready, 1'b1);
    step();
    bus.rdata = 32'h2;
    #2 resetn = 1'b0;
    @(negedge clk);
    checkOutput("t6_arvalid", bus.arvalid, 1'b0);
    checkOutput("t6_rready", bus.rready, 1'b0);
    checkOutput("t6_awvalid", bus.awvalid, 1'b0);
    checkOutput("t6_wvalid", bus.wvalid, 1'b0);
    checkOutput("t6_bready", bus.bready, 1'b0);
    applyStimulus();
    step();
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("t6_rd_rdy", bus.rd_rdy, 1'b1);
    checkOutput("t6_wr_rdy", bus.wr_rdy, 1'b1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
